logic_eval_arbiter: RTL and testbench



---
 rtl/logic_eval_arbiter.sv | 103 ++++++++++
 tb/tb_logic_eval_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/logic_eval_arbiter.sv
// Round-robin sequencer for a shared unclocked 5-input evaluator: accepts a vector,
// waits SETTLE_CYCLES for the gate delays to resolve, then returns Y to its owner.
module logic_eval_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 2  // legal range 1..15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [4:0] req0_vec,
  output logic       req0_ready,
  output logic       rsp0_valid,
  output logic       rsp0_y,
  input  logic       req1_valid,
  input  logic [4:0] req1_vec,
  output logic       req1_ready,
  output logic       rsp1_valid,
  output logic       rsp1_y,
  output logic [4:0] eval_vec,
  input  logic       eval_y,
  output logic       busy,
  output logic [7:0] eval_count,
  output logic       state_dbg
);

  typedef enum logic {IDLE = 1'b0, SETTLE = 1'b1} state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t     state, state_nxt;
  logic       last_served;
  logic       owner;
  logic [3:0] cnt;
  logic       any_valid;
  logic       grant;
  logic       accept;

  // Handshake: a vector transfers on a rising edge where reqN_valid && reqN_ready.
  // Ready never waits on anything but IDLE and the arbitration result, and at most
  // one ready is high; responses are single-cycle pulses with no backpressure.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    grant     = (req0_valid && req1_valid) ? ~last_served : req1_valid;
    accept    = (state == IDLE) && any_valid;
  end

  assign req0_ready = accept && (grant == 1'b0);
  assign req1_ready = accept && (grant == 1'b1);
  assign busy       = (state == SETTLE);
  assign state_dbg  = state;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETTLE;
      SETTLE:  if (cnt == 4'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Reset leaves last_served=1 so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_served <= 1'b1;
      owner       <= 1'b0;
      cnt         <= 4'd0;
      eval_vec    <= 5'd0;
      rsp0_valid  <= 1'b0;
      rsp0_y      <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp1_y      <= 1'b0;
      eval_count  <= 8'd0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      if (accept) begin
        eval_vec    <= grant ? req1_vec : req0_vec;
        owner       <= grant;
        last_served <= grant;
        cnt         <= CNT_INIT;
      end
      if (state == SETTLE) begin
        if (cnt == 4'd0) begin
          if (owner) begin
            rsp1_y     <= eval_y;
            rsp1_valid <= 1'b1;
          end else begin
            rsp0_y     <= eval_y;
            rsp0_valid <= 1'b1;
          end
          eval_count <= eval_count + 8'd1;
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_logic_eval_arbiter.sv
// Bench for logic_eval_arbiter: two instances (SETTLE_CYCLES=2 and 1), each with a
// delayed evaluator model and a scoreboard checking owner, Y, eval_count and timing.
module tb_logic_eval_arbiter;

  localparam int W = 30;  // {id, y, count[7:0], cycle[19:0]}

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  logic       a_req0_valid = 0, a_req1_valid = 0, b_req0_valid = 0, b_req1_valid = 0;
  logic [4:0] a_req0_vec = 0, a_req1_vec = 0, b_req0_vec = 0, b_req1_vec = 0;
  logic       a_req0_ready, a_req1_ready, a_rsp0_valid, a_rsp1_valid, a_rsp0_y, a_rsp1_y;
  logic       b_req0_ready, b_req1_ready, b_rsp0_valid, b_rsp1_valid, b_rsp0_y, b_rsp1_y;
  logic [4:0] a_eval_vec, b_eval_vec;
  logic       a_eval_y = 1'b0, b_eval_y = 1'b0;
  logic       a_busy, b_busy, a_state_dbg, b_state_dbg;
  logic [7:0] a_eval_count, b_eval_count;
  logic [7:0] a_cnt_model = 0, b_cnt_model = 0;

  logic [W-1:0] a_q[$];
  logic [W-1:0] b_q[$];

  logic_eval_arbiter #(.SETTLE_CYCLES(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(a_req0_valid), .req0_vec(a_req0_vec), .req0_ready(a_req0_ready),
    .rsp0_valid(a_rsp0_valid), .rsp0_y(a_rsp0_y),
    .req1_valid(a_req1_valid), .req1_vec(a_req1_vec), .req1_ready(a_req1_ready),
    .rsp1_valid(a_rsp1_valid), .rsp1_y(a_rsp1_y),
    .eval_vec(a_eval_vec), .eval_y(a_eval_y), .busy(a_busy),
    .eval_count(a_eval_count), .state_dbg(a_state_dbg)
  );

  logic_eval_arbiter #(.SETTLE_CYCLES(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(b_req0_valid), .req0_vec(b_req0_vec), .req0_ready(b_req0_ready),
    .rsp0_valid(b_rsp0_valid), .rsp0_y(b_rsp0_y),
    .req1_valid(b_req1_valid), .req1_vec(b_req1_vec), .req1_ready(b_req1_ready),
    .rsp1_valid(b_rsp1_valid), .rsp1_y(b_rsp1_y),
    .eval_vec(b_eval_vec), .eval_y(b_eval_y), .busy(b_busy),
    .eval_count(b_eval_count), .state_dbg(b_state_dbg)
  );

  // clock / reset / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Evaluator: Y = A.B'.C' + B.C.D'.E; shows the wrong value until just before
  // the legal sample edge so an early sample is caught.
  function automatic logic eval_fn(input logic [4:0] v);
    return (v[4] & ~v[3] & ~v[2]) | (v[3] & v[2] & ~v[1] & v[0]);
  endfunction

  always begin
    @(a_eval_vec);
    a_eval_y = ~eval_fn(a_eval_vec);
    #15;
    a_eval_y = eval_fn(a_eval_vec);
  end

  always begin
    @(b_eval_vec);
    b_eval_y = ~eval_fn(b_eval_vec);
    #5;
    b_eval_y = eval_fn(b_eval_vec);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_a(input logic id, input logic y, input int c);
    a_cnt_model = a_cnt_model + 8'd1;
    a_q.push_back({id, y, a_cnt_model, 20'(c)});
  endtask

  task automatic push_b(input logic id, input logic y, input int c);
    b_cnt_model = b_cnt_model + 8'd1;
    b_q.push_back({id, y, b_cnt_model, 20'(c)});
  endtask

  // driver: called at a negedge; holds the valids for 'edges' rising edges
  task automatic drive(input bit inst, input logic v0, input logic v1,
                       input logic [4:0] x0, input logic [4:0] x1, input int edges);
    if (inst == 1'b0) begin
      a_req0_valid = v0; a_req1_valid = v1; a_req0_vec = x0; a_req1_vec = x1;
    end else begin
      b_req0_valid = v0; b_req1_valid = v1; b_req0_vec = x0; b_req1_vec = x1;
    end
    repeat (edges) @(posedge clk);
    @(negedge clk);
    a_req0_valid = 0; a_req1_valid = 0; b_req0_valid = 0; b_req1_valid = 0;
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n && (a_rsp0_valid || a_rsp1_valid)) begin
      if (a_rsp0_valid && a_rsp1_valid) chk("a_both_rsp", 1, 0);
      if (a_q.size() == 0) begin
        chk("a_unexpected_rsp", {a_rsp1_valid, a_rsp0_valid}, 0);
      end else begin
        e = a_q.pop_front();
        chk("a_rsp_id", a_rsp1_valid, e[29]);
        chk("a_rsp_y", a_rsp1_valid ? a_rsp1_y : a_rsp0_y, e[28]);
        chk("a_rsp_count", a_eval_count, e[27:20]);
        chk("a_rsp_cycle", 20'(cyc), e[19:0]);
      end
    end
  end

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n && (b_rsp0_valid || b_rsp1_valid)) begin
      if (b_rsp0_valid && b_rsp1_valid) chk("b_both_rsp", 1, 0);
      if (b_q.size() == 0) begin
        chk("b_unexpected_rsp", {b_rsp1_valid, b_rsp0_valid}, 0);
      end else begin
        e = b_q.pop_front();
        chk("b_rsp_id", b_rsp1_valid, e[29]);
        chk("b_rsp_y", b_rsp1_valid ? b_rsp1_y : b_rsp0_y, e[28]);
        chk("b_rsp_count", b_eval_count, e[27:20]);
        chk("b_rsp_cycle", 20'(cyc), e[19:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    // reset values
    #1 rst_n = 0;
    #2;
    chk("rst_eval_vec", a_eval_vec, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_count", a_eval_count, 0);
    chk("rst_rsp", {a_rsp0_valid, a_rsp1_valid, a_rsp0_y, a_rsp1_y}, 0);
    chk("rst_b_count", b_eval_count, 0);
    a_req0_valid = 1; a_req1_valid = 1;
    #1 chk("rst_ready_req0_wins", {a_req0_ready, a_req1_ready}, 2'b10);
    a_req0_valid = 0; a_req1_valid = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1;

    // SETTLE_CYCLES=1: response cycle doubles as the next acceptance cycle
    @(negedge clk); c0 = cyc;
    push_b(0, 1, c0 + 2);
    push_b(1, 0, c0 + 4);
    drive(1, 1, 1, 5'b01101, 5'b01010, 3);
    chk("b_eval_vec", b_eval_vec, 5'b01010);
    repeat (3) @(negedge clk);

    // contention: 0,1,0,1
    c0 = cyc;
    push_a(0, 1, c0 + 3);
    push_a(1, 0, c0 + 6);
    push_a(0, 1, c0 + 9);
    push_a(1, 0, c0 + 12);
    drive(0, 1, 1, 5'b10000, 5'b01010, 10);
    repeat (3) @(negedge clk);

    // single request on requester 0
    c0 = cyc;
    push_a(0, 1, c0 + 3);
    drive(0, 1, 0, 5'b01101, 5'b00000, 1);
    chk("single_eval_vec", a_eval_vec, 5'b01101);
    chk("single_busy", a_busy, 1);
    chk("single_state", a_state_dbg, 1);
    a_req0_valid = 1; a_req1_valid = 1;
    #1 chk("settle_ready_low", {a_req0_ready, a_req1_ready}, 2'b00);
    a_req0_valid = 0; a_req1_valid = 0;
    repeat (3) @(negedge clk);
    chk("hold_rsp0_y", a_rsp0_y, 1);
    chk("hold_rsp1_y", a_rsp1_y, 0);
    chk("idle_busy", a_busy, 0);

    // back-to-back on requester 1
    c0 = cyc;
    push_a(1, 1, c0 + 3);
    push_a(1, 1, c0 + 6);
    push_a(1, 1, c0 + 9);
    drive(0, 0, 1, 5'b00000, 5'b10011, 7);
    repeat (3) @(negedge clk);
    chk("b2b_count", a_eval_count, 8);

    // reset one cycle after acceptance aborts the evaluation
    drive(0, 1, 0, 5'b11011, 5'b00000, 1);
    @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("abort_eval_vec", a_eval_vec, 0);
    chk("abort_count", a_eval_count, 0);
    chk("abort_busy", a_busy, 0);
    chk("abort_rsp", {a_rsp0_valid, a_rsp1_valid, a_rsp0_y, a_rsp1_y}, 0);
    a_cnt_model = 0; b_cnt_model = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk); c0 = cyc;
    push_a(0, 1, c0 + 3);
    push_a(1, 0, c0 + 6);
    drive(0, 1, 1, 5'b10000, 5'b01010, 4);
    repeat (3) @(negedge clk);

    // 256 evaluations: count passes 255 then 0, ending back at 2
    c0 = cyc;
    for (int i = 0; i < 256; i++) push_a(1, 1, c0 + 3 + 3 * i);
    drive(0, 0, 1, 5'b00000, 5'b10011, 766);
    repeat (4) @(negedge clk);
    chk("wrap_count", a_eval_count, 2);

    chk("a_queue_drained", a_q.size(), 0);
    chk("b_queue_drained", b_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
